// File: rtl/qed_pkg.sv
// Shared types and helpers for the QED consistency monitors.
// Provides the monitor state encoding, half-size helpers and the error location record.
package qed_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG_SCAN,
    MEM_A,
    MEM_B,
    MEM_CMP,
    DONE
  } qed_mon_state_t;

  localparam int ERR_IDX_W = 16;

  typedef struct packed {
    logic                 is_mem;
    logic [ERR_IDX_W-1:0] index;
  } err_loc_t;

  function automatic int half_regs(input int num_regs);
    return num_regs / 2;
  endfunction

  function automatic int half_mem(input int mem_words);
    return mem_words / 2;
  endfunction

endpackage

// File: rtl/qed_pair_scanner.sv
// Walks the lower index of original/duplicate pairs and flags the first
// mismatch seen since the last clear.
// Ports: clr (restart at START), adv (a pair is compared this cycle),
//        mis (that pair differs), idx (current lower index),
//        last (idx is the final pair), first_mis (first mismatch since clr).
module qed_pair_scanner #(
  parameter int IDXW  = 5,
  parameter int START = 0,
  parameter int LAST  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            adv,
  input  logic            mis,
  output logic [IDXW-1:0] idx,
  output logic            last,
  output logic            first_mis
);

  logic [IDXW-1:0] idx_q, idx_d;
  logic            found_q, found_d;

  assign idx       = idx_q;
  assign last      = (idx_q == IDXW'(LAST));
  assign first_mis = adv && mis && !found_q;

  always_comb begin
    idx_d   = idx_q;
    found_d = found_q;
    if (clr) begin
      idx_d   = IDXW'(START);
      found_d = 1'b0;
    end else if (adv) begin
      if (mis) found_d = 1'b1;
      // Index parks on the last pair; the FSM leaves the phase there.
      if (!last) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      found_q <= found_d;
    end
  end

endmodule

// File: rtl/qed_consistency_monitor.sv
// SQED consistency checker: snapshots the register file on check_req, then
// compares register pairs (i, i+NUM_REGS/2) and memory pairs (k, k+MEM_WORDS/2).
// Ports: clk/rst, check_req trigger, regs_flat taps, mem_rd_* read port,
//        busy/done/pass status, sticky error + first-mismatch location,
//        overrun flag and accepted-check counter.
module qed_consistency_monitor
  import qed_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int SKIP_R0   = 1,
  parameter int MEM_WORDS = 32,
  parameter int MEM_AW    = 5,
  parameter int IDXW      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     check_req,
  input  logic [NUM_REGS*XLEN-1:0] regs_flat,
  output logic                     mem_rd_en,
  output logic [MEM_AW-1:0]        mem_rd_addr,
  input  logic [XLEN-1:0]          mem_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     err_sticky,
  output logic                     err_is_mem,
  output logic [IDXW-1:0]          err_index,
  output logic                     overrun,
  output logic [15:0]              check_cnt
);

  localparam int HALF_REGS = half_regs(NUM_REGS);
  localparam int HALF_MEM  = half_mem(MEM_WORDS);
  localparam bit HAS_REGS  = HALF_REGS > SKIP_R0;
  localparam bit HAS_MEM   = HALF_MEM > 0;
  localparam int REG_START = (SKIP_R0 != 0) ? 1 : 0;
  localparam int REG_LAST  = HALF_REGS - 1;
  localparam int MEM_LAST  = HAS_MEM ? HALF_MEM - 1 : 0;

  qed_mon_state_t state_q, state_d;

  logic [XLEN-1:0] snap_q [NUM_REGS];
  logic [XLEN-1:0] snap_d [NUM_REGS];
  logic [XLEN-1:0] word_a_q, word_a_d;
  logic            fail_q, fail_d;
  logic            pass_q, pass_d;
  logic            sticky_q, sticky_d;
  logic            is_mem_q, is_mem_d;
  logic [IDXW-1:0] index_q, index_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            trig;
  logic [XLEN-1:0] reg_a, reg_b;
  logic            reg_adv, reg_mis, reg_last, reg_first;
  logic            mem_adv, mem_mis, mem_last, mem_first;
  logic [IDXW-1:0] reg_idx, mem_idx;

  assign trig    = check_req && (state_q == IDLE);
  assign reg_adv = (state_q == REG_SCAN);
  assign mem_adv = (state_q == MEM_CMP);
  assign reg_mis = reg_adv && (reg_a != reg_b);
  assign mem_mis = mem_adv && (word_a_q != mem_rd_data);

  always_comb begin
    reg_a = '0;
    reg_b = '0;
    for (int p = 0; p < HALF_REGS; p++) begin
      if (reg_idx == IDXW'(p)) begin
        reg_a = snap_q[p];
        reg_b = snap_q[p+HALF_REGS];
      end
    end
  end

  qed_pair_scanner #(
    .IDXW (IDXW),
    .START(REG_START),
    .LAST (REG_LAST)
  ) u_reg_scan (
    .clk      (clk),
    .rst      (rst),
    .clr      (trig),
    .adv      (reg_adv),
    .mis      (reg_a != reg_b),
    .idx      (reg_idx),
    .last     (reg_last),
    .first_mis(reg_first)
  );

  qed_pair_scanner #(
    .IDXW (IDXW),
    .START(0),
    .LAST (MEM_LAST)
  ) u_mem_scan (
    .clk      (clk),
    .rst      (rst),
    .clr      (trig),
    .adv      (mem_adv),
    .mis      (word_a_q != mem_rd_data),
    .idx      (mem_idx),
    .last     (mem_last),
    .first_mis(mem_first)
  );

  always_comb begin
    snap_d = snap_q;
    if (trig) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_d[i] = regs_flat[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    word_a_d = word_a_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    sticky_d = sticky_q;
    is_mem_d = is_mem_q;
    index_d  = index_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;

    if (check_req && (state_q != IDLE)) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (check_req) begin
          cnt_d  = cnt_q + 16'd1;
          fail_d = 1'b0;
          if (HAS_REGS)     state_d = REG_SCAN;
          else if (HAS_MEM) state_d = MEM_A;
          else              state_d = DONE;
        end
      end
      REG_SCAN: begin
        if (reg_last) state_d = HAS_MEM ? MEM_A : DONE;
      end
      MEM_A:   state_d = MEM_B;
      MEM_B: begin
        word_a_d = mem_rd_data;
        state_d  = MEM_CMP;
      end
      MEM_CMP: state_d = mem_last ? DONE : MEM_A;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (reg_mis || mem_mis) begin
      fail_d   = 1'b1;
      sticky_d = 1'b1;
    end

    // Register phase precedes memory, so a memory hit is only the first
    // mismatch of the check when no register pair has failed.
    if (reg_first) begin
      is_mem_d = 1'b0;
      index_d  = reg_idx;
    end else if (mem_first && !fail_q) begin
      is_mem_d = 1'b1;
      index_d  = mem_idx;
    end

    if ((state_d == DONE) && (state_q != DONE)) pass_d = !fail_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
      word_a_q <= '0;
      fail_q   <= 1'b0;
      pass_q   <= 1'b0;
      sticky_q <= 1'b0;
      is_mem_q <= 1'b0;
      index_q  <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      word_a_q <= word_a_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      sticky_q <= sticky_d;
      is_mem_q <= is_mem_d;
      index_q  <= index_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    mem_rd_addr = '0;
    if (state_q == MEM_A) mem_rd_addr = MEM_AW'(mem_idx);
    if (state_q == MEM_B) begin
      mem_rd_addr = MEM_AW'(mem_idx) + MEM_AW'(HALF_MEM);
    end
  end

  assign mem_rd_en  = (state_q == MEM_A) || (state_q == MEM_B);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_sticky = sticky_q;
  assign err_is_mem = is_mem_q;
  assign err_index  = index_q;
  assign overrun    = ovr_q;
  assign check_cnt  = cnt_q;

endmodule

// File: tb/tb_qed_consistency_monitor.sv
// Scoreboard bench for qed_consistency_monitor: default instance plus a
// register-only instance (MEM_WORDS=0).
module tb_qed_consistency_monitor;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int MW   = 32;
  localparam int AW   = 5;
  localparam int IW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req_a, req_b;
  logic [XLEN-1:0] regs_a [NR];
  logic [XLEN-1:0] regs_b [NR];
  logic [NR*XLEN-1:0] flat_a, flat_b;
  logic [XLEN-1:0] mem [MW];
  logic [XLEN-1:0] rdata_a;
  logic [XLEN-1:0] rdata_b;

  logic en_a, busy_a, done_a, pass_a, sticky_a, ism_a, ovr_a;
  logic [AW-1:0] addr_a;
  logic [IW-1:0] idx_a;
  logic [15:0] cnt_a;
  logic en_b, busy_b, done_b, pass_b, sticky_b, ism_b, ovr_b;
  logic [AW-1:0] addr_b;
  logic [IW-1:0] idx_b;
  logic [15:0] cnt_b;

  always_comb begin
    flat_a = '0;
    flat_b = '0;
    for (int i = 0; i < NR; i++) begin
      flat_a[i*XLEN +: XLEN] = regs_a[i];
      flat_b[i*XLEN +: XLEN] = regs_b[i];
    end
  end

  assign rdata_b = '0;

  always @(posedge clk) begin
    if (en_a) rdata_a <= mem[addr_a];
  end

  qed_consistency_monitor #(
    .XLEN(XLEN), .NUM_REGS(NR), .SKIP_R0(1),
    .MEM_WORDS(MW), .MEM_AW(AW), .IDXW(IW)
  ) u_dut (
    .clk(clk), .rst(rst), .check_req(req_a),
    .regs_flat(flat_a),
    .mem_rd_en(en_a), .mem_rd_addr(addr_a),
    .mem_rd_data(rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_sticky(sticky_a), .err_is_mem(ism_a),
    .err_index(idx_a), .overrun(ovr_a),
    .check_cnt(cnt_a)
  );

  qed_consistency_monitor #(
    .XLEN(XLEN), .NUM_REGS(NR), .SKIP_R0(1),
    .MEM_WORDS(0), .MEM_AW(AW), .IDXW(IW)
  ) u_nomem (
    .clk(clk), .rst(rst), .check_req(req_b),
    .regs_flat(flat_b),
    .mem_rd_en(en_b), .mem_rd_addr(addr_b),
    .mem_rd_data(rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_sticky(sticky_b), .err_is_mem(ism_b),
    .err_index(idx_b), .overrun(ovr_b),
    .check_cnt(cnt_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dcyc;
    bit pass;
    bit sticky;
    bit ism;
    int idx;
    int cnt;
    bit ovr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   addr_log[$];
  bit   en_b_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cmp_done(input string p, input exp_t e,
                          input bit ps, input bit st, input bit im,
                          input int ix, input int cn, input bit ov);
    chk({p, "_done_cycle"}, cyc, e.dcyc);
    chk({p, "_pass"}, ps, e.pass);
    chk({p, "_err_sticky"}, st, e.sticky);
    chk({p, "_err_is_mem"}, im, e.ism);
    chk({p, "_err_index"}, ix, e.idx);
    chk({p, "_check_cnt"}, cn, e.cnt);
    chk({p, "_overrun"}, ov, e.ovr);
  endtask

  // Monitors: pop an expectation whenever a DUT pulses done.
  always @(negedge clk) begin
    if (en_a) addr_log.push_back(int'(addr_a));
    if (done_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        cmp_done("a", q_a.pop_front(), pass_a, sticky_a, ism_a,
                 int'(idx_a), int'(cnt_a), ovr_a);
      end
    end
  end

  always @(negedge clk) begin
    if (en_b) en_b_seen = 1'b1;
    if (done_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        cmp_done("b", q_b.pop_front(), pass_b, sticky_b, ism_b,
                 int'(idx_b), int'(cnt_b), ovr_b);
      end
    end
  end

  // Pulse check_req for one cycle; t is the sampling edge.
  // done is visible in the cycle just before edge t+lat.
  task automatic issue(input bit b, input bit push, input int lat,
                       input bit ps, input bit st, input bit im,
                       input int ix, input int cn, input bit ov,
                       output int t);
    exp_t e;
    @(negedge clk);
    if (b) req_b = 1'b1;
    else   req_a = 1'b1;
    t = cyc + 1;
    e.dcyc   = t + lat - 1;
    e.pass   = ps;
    e.sticky = st;
    e.ism    = im;
    e.idx    = ix;
    e.cnt    = cn;
    e.ovr    = ov;
    if (push) begin
      if (b) q_b.push_back(e);
      else   q_a.push_back(e);
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic wait_q(input bit b, input string name);
    int n;
    n = 0;
    while ((b ? q_b.size() : q_a.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, b ? q_b.size() : q_a.size(), 0);
    q_a.delete();
    q_b.delete();
  endtask

  task automatic init_data();
    for (int i = 0; i < NR / 2; i++) begin
      regs_a[i]        = 32'h1000_0000 + i * 257;
      regs_a[i+NR/2]   = 32'h1000_0000 + i * 257;
      regs_b[i]        = 32'h2000_0000 + i * 3;
      regs_b[i+NR/2]   = 32'h2000_0000 + i * 3;
    end
    for (int k = 0; k < MW / 2; k++) begin
      mem[k]      = 32'hC0DE_0000 ^ (k * 32'h0001_0011);
      mem[k+MW/2] = 32'hC0DE_0000 ^ (k * 32'h0001_0011);
    end
  endtask

  int t;
  int bad;

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    init_data();
    repeat (3) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_sticky", sticky_a, 0);
    chk("rst_rd_en", en_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_index", idx_a, 0);
    rst = 1'b0;

    // 1: clean check, latency 64, address order
    addr_log.delete();
    issue(0, 1, 64, 1, 0, 0, 0, 1, 0, t);
    chk("busy_after_trig", busy_a, 1);
    wait_q(0, "t1_drain");
    chk("addr_count", addr_log.size(), 32);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (addr_log.size() == 32) begin
        if (addr_log[2*k] != k) bad++;
        if (addr_log[2*k+1] != k + 16) bad++;
      end
    end
    chk("addr_order_bad", bad, 0);

    // 2: register mismatch, then clean check keeps sticky/index
    regs_a[5]  = 32'hDEAD;
    regs_a[21] = 32'hBEEF;
    issue(0, 1, 64, 0, 1, 0, 5, 2, 0, t);
    wait_q(0, "t2a_drain");
    init_data();
    issue(0, 1, 64, 1, 1, 0, 5, 3, 0, t);
    wait_q(0, "t2b_drain");

    // 3: register failure wins over a later memory failure
    regs_a[7]  = 32'h1;
    regs_a[23] = 32'h2;
    mem[3]     = 32'hAAAA;
    mem[19]    = 32'h5555;
    issue(0, 1, 64, 0, 1, 0, 7, 4, 0, t);
    wait_q(0, "t3a_drain");
    init_data();
    mem[3]  = 32'hAAAA;
    mem[19] = 32'h5555;
    issue(0, 1, 64, 0, 1, 1, 3, 5, 0, t);
    wait_q(0, "t3b_drain");
    // reg0 pair is skipped; last register pair is reported
    init_data();
    regs_a[0]  = 32'h1;
    regs_a[15] = 32'h0;
    issue(0, 1, 64, 0, 1, 0, 15, 6, 0, t);
    wait_q(0, "t3c_drain");
    init_data();
    mem[31] = 32'h0;
    issue(0, 1, 64, 0, 1, 1, 15, 7, 0, t);
    wait_q(0, "t3d_drain");
    init_data();
    regs_a[0] = 32'h1;
    issue(0, 1, 64, 1, 1, 1, 15, 8, 0, t);
    wait_q(0, "t3e_drain");
    init_data();

    // 4: request during a check is dropped and flagged
    issue(0, 1, 64, 1, 1, 1, 15, 9, 1, t);
    repeat (9) @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    chk("ovr_mid_check", ovr_a, 1);
    chk("cnt_mid_check", cnt_a, 9);
    wait_q(0, "t4_drain");

    // 5: asynchronous reset while in MEM_B
    issue(0, 0, 64, 0, 0, 0, 0, 0, 0, t);
    repeat (16) @(negedge clk);
    chk("pre_rst_rd_en", en_a, 1);
    chk("pre_rst_addr", addr_a, 16);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", en_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_sticky", sticky_a, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1, 64, 1, 0, 0, 0, 1, 0, t);
    // request landing in the DONE cycle is ignored
    repeat (63) @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    chk("done_cycle_ovr", ovr_a, 1);
    chk("done_cycle_cnt", cnt_a, 1);
    chk("done_cycle_busy", busy_a, 0);
    wait_q(0, "t5_drain");

    // 6: no memory phase, register-only latency
    regs_b[0]  = 32'h1;
    regs_b[16] = 32'h0;
    issue(1, 1, 16, 1, 0, 0, 0, 1, 0, t);
    wait_q(1, "t6_drain");
    chk("nomem_rd_en_seen", en_b_seen, 0);
    chk("nomem_addr", addr_b, 0);
    chk("nomem_busy", busy_b, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qed_consistency_monitor.md
Name: qed_consistency_monitor

Overview:
Synthesizable, parametrised QED consistency checker for the SQED flow. It runs on silicon and emulation targets as well as under formal.
- On a check trigger (qed_check_valid && commit), it snapshots the architectural register file.
- It then scans original/duplicate pairs one per cycle: register i vs i+NUM_REGS/2, then memory word k vs k+MEM_WORDS/2 through a read port.
- It reports pass/fail, the first mismatch location, and a sticky error flag.
- It sits beside the DUT in design_top, fed by the register-file taps and a spare data-memory read port.

Parameters:
- XLEN, 32, datapath width of registers and memory words.
- NUM_REGS, 32, architectural registers; must be even. Pair i is (i, i+NUM_REGS/2).
- SKIP_R0, 1, when 1 the pair starting at register 0 is not compared.
- MEM_WORDS, 32, checked memory words; must be even. 0 removes the memory phase.
- MEM_AW, 5, memory address width; must satisfy 2**MEM_AW >= MEM_WORDS.
- IDXW, 5, err_index width; must satisfy 2**IDXW >= max(NUM_REGS/2, MEM_WORDS/2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- check_req  in  1  single-cycle trigger; sampled only in IDLE.
- regs_flat  in  NUM_REGS*XLEN  register file; register i occupies bits [i*XLEN +: XLEN].
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  MEM_AW  read address.
- mem_rd_data  in  XLEN  read data, valid exactly one cycle after mem_rd_en.
- busy  out  1  a check is in progress.
- done  out  1  one-cycle pulse at the end of a check.
- pass  out  1  result of the last completed check; valid from done onward.
- err_sticky  out  1  set by any mismatch; cleared only by rst.
- err_is_mem  out  1  first mismatch of the last failing check was in memory.
- err_index  out  IDXW  lower index of the first mismatching pair.
- overrun  out  1  sticky; set when check_req arrives while not in IDLE.
- check_cnt  out  16  accepted checks; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0, state IDLE, snapshot 0. Reset is asynchronous; a mid-check reset aborts the check, and mem_rd_en drops with rst.
- States: IDLE, REG_SCAN, MEM_A, MEM_B, MEM_CMP, DONE.
- IDLE: on check_req at edge T:
  - snapshot regs_flat;
  - set i = SKIP_R0;
  - check_cnt++;
  - clear the per-check fail and first-captured flags;
  - go to REG_SCAN.
  busy is high from T+1 through DONE inclusive.
- REG_SCAN: compare snap[i] with snap[i+NUM_REGS/2] each cycle.
  - At i = NUM_REGS/2-1: go to MEM_A if MEM_WORDS > 0, else DONE.
  - If SKIP_R0=1 and NUM_REGS=2, REG_SCAN has no pairs: go straight to MEM_A or DONE.
- MEM_A: mem_rd_en=1, addr=k.
- MEM_B: mem_rd_en=1, addr=k+MEM_WORDS/2; capture mem_rd_data as word A.
- MEM_CMP: compare word A with mem_rd_data.
  - k == MEM_WORDS/2-1: go to DONE.
  - Otherwise: k++ and go to MEM_A.
  - Memory is read live, not snapshotted; the DUT is stalled by the SQED harness during checks.
- DONE: done=1 for one cycle; pass = !fail; then IDLE. Registers updated at T+1 are not seen, because the snapshot is taken at T.
- Mismatch:
  - fail=1 and err_sticky=1 on every mismatch.
  - err_index/err_is_mem are written only on the first mismatch of a check and hold until the next failing check.
  - The scan always completes; there is no early exit.
- Latency: done at T + P_R + 3*MEM_WORDS/2 + 1, where P_R = NUM_REGS/2 - SKIP_R0. Defaults give T+64.
- Index counters are sized to IDXW. Comparisons are exact full-XLEN equality.
- check_req outside IDLE: ignored (not queued), overrun=1, check_cnt unchanged. A check_req in the DONE cycle is also ignored and sets overrun.

Decomposition:
- Package qed_pkg:
  - state enum qed_mon_state_t;
  - localparam helpers HALF_REGS and HALF_MEM;
  - an err_loc_t struct {is_mem, index}, reused by future QED monitors.
- One natural sub-module, qed_pair_scanner: index counter, start/last detection and first-mismatch capture. It is instantiated once for the register phase and once for the memory phase. The top level holds the FSM, snapshot and memory port.

Test Plan:
1. Defaults, all pairs equal, check_req at T -> done at T+64; pass=1; err_sticky=0; check_cnt=1; mem_rd_addr sequence 0,16,1,17,...,15,31.
2. reg5=0xDEAD, reg21=0xBEEF -> pass=0; err_is_mem=0; err_index=5; err_sticky=1. A following clean check gives pass=1, err_sticky still 1, err_index still 5.
3. Mismatches at reg7/reg23 and mem[3]/mem[19] -> err_is_mem=0, err_index=7.
4. check_req at T+10 during a check -> ignored; overrun=1; check_cnt=1; done still at T+64.
5. rst pulsed while in MEM_B -> mem_rd_en, busy, done, check_cnt read 0 immediately; state IDLE; a new check after reset runs normally.
6. MEM_WORDS=0, SKIP_R0=1, reg0=1 with reg16=0 -> done at T+16, pass=1, mem_rd_en never asserted.
